// File: rtl/uart_user_echo.sv
// User-side echo endpoint for uart_driver: buffers received bytes in a FIFO and returns them
// in order on the TX valid/ready stream, optionally expanding CR into CR,LF.
module uart_user_echo #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_FIFO_DEPTH = 16,
  parameter int P_ADD_LF     = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [P_DATA_WIDTH-1:0]         i_user_rx_data,
  input  logic                            i_user_rx_valid,
  output logic [P_DATA_WIDTH-1:0]         o_user_tx_data,
  output logic                            o_user_tx_valid,
  input  logic                            i_user_tx_ready,
  input  logic                            i_ovf_clr,
  output logic                            o_overflow,
  output logic [7:0]                      o_drop_cnt,
  output logic [$clog2(P_FIFO_DEPTH):0]   o_fifo_level
);

  localparam int L_AW = $clog2(P_FIFO_DEPTH);
  localparam int L_LW = L_AW + 1;
  localparam logic [P_DATA_WIDTH-1:0] L_CR = P_DATA_WIDTH'(8'h0D);
  localparam logic [P_DATA_WIDTH-1:0] L_LF = P_DATA_WIDTH'(8'h0A);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_SEND_LF = 2'd2;

  logic [P_DATA_WIDTH-1:0] mem_q [P_FIFO_DEPTH];
  logic [L_AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [L_AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [L_LW-1:0]         level_q, level_d;
  logic [1:0]              state_q, state_d;
  logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              drop_q, drop_d;

  logic full_s, wr_en_s, drop_s, hs_s, free_s;

  // The head entry stays counted in the level while it is being offered; it is freed on
  // the handshake of the data byte, so a stalled byte still occupies a FIFO slot.
  assign full_s  = (level_q == L_LW'(P_FIFO_DEPTH));
  assign wr_en_s = i_user_rx_valid && !full_s;
  assign drop_s  = i_user_rx_valid && full_s;
  assign hs_s    = tx_valid_q && i_user_tx_ready;
  assign free_s  = (state_q == S_SEND) && hs_s;

  // Next-state logic: FIFO pointers/level, echo FSM and overflow bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + L_AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (free_s) begin
      rd_ptr_d = rd_ptr_q + L_AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, free_s})
      2'b10:   level_d = level_q + L_LW'(1);
      2'b01:   level_d = level_q - L_LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (level_q != L_LW'(0)) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (hs_s) begin
          if ((P_ADD_LF != 0) && (tx_data_q == L_CR)) begin
            tx_data_d = L_LF;
            state_d   = S_SEND_LF;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND_LF: begin
        if (hs_s) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_SEND_LF;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    // Clear wins over a drop in the same cycle.
    if (i_ovf_clr) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end else if (drop_s) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == 8'd255) ? 8'd255 : drop_q + 8'd1;
    end else begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= i_user_rx_data;
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q   <= L_AW'(0);
      rd_ptr_q   <= L_AW'(0);
      level_q    <= L_LW'(0);
      state_q    <= S_IDLE;
      tx_data_q  <= P_DATA_WIDTH'(0);
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign o_user_tx_data  = tx_data_q;
  assign o_user_tx_valid = tx_valid_q;
  assign o_overflow      = ovf_q;
  assign o_drop_cnt      = drop_q;
  assign o_fifo_level    = level_q;

endmodule
